// File: rtl/serial_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_deser_pkg
// Purpose  : Shared types and defaults for the serial deserializer.
// Revision : 1.0
// ============================================================================
package serial_deser_pkg;

    typedef enum logic {IDLE, COLLECT} deser_state_t;

    localparam int DESER_DEFAULT_WIDTH = 4;

endpackage
`default_nettype wire

// File: rtl/deser_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : deser_out_reg
// Purpose  : WIDTH-bit valid/ready holding register with overrun detect.
// Revision : 1.0
// ============================================================================
module deser_out_reg
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = DESER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    output logic             o_overrun_set
);

    logic [WIDTH-1:0] r_word;
    logic             r_valid;

    // A new word is dropped only when the held one is neither empty nor retiring.
    assign o_overrun_set = i_load && r_valid && !i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            if (!r_valid || i_ready) begin
                r_word  <= i_load_data;
                r_valid <= 1'b1;
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : serial_deserializer
// Purpose  : Reassembles MSB-first start-framed serial bits into WIDTH-bit words.
// Revision : 1.0
// ============================================================================
module serial_deserializer
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = DESER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             start,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    deser_state_t     r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_frame_err;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shift;
    logic             w_last;
    logic             w_complete;
    logic             w_overrun_set;

    assign w_shift    = (r_sr << 1) | WIDTH'(bit_in);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_complete = (r_state == COLLECT) && bit_valid && !start && w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bit_valid && start) begin
                        r_sr    <= WIDTH'(bit_in);
                        r_cnt   <= CW'(1);
                        r_state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bit_valid) begin
                        if (start) begin
                            // Resync: the marked bit opens a fresh frame.
                            r_sr        <= WIDTH'(bit_in);
                            r_cnt       <= CW'(1);
                            r_frame_err <= 1'b1;
                        end else if (w_last) begin
                            r_sr    <= w_shift;
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_sr  <= w_shift;
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    deser_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_complete),
        .i_load_data  (w_shift),
        .i_ready      (out_ready),
        .o_word       (word_out),
        .o_valid      (word_valid),
        .o_overrun_set(w_overrun_set)
    );

    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_deserializer
// Purpose  : Directed self-checking bench for serial_deserializer (WIDTH=4).
// Revision : 1.0
// ============================================================================
module tb_serial_deserializer;

    logic       clk;
    logic       reset;
    logic       bit_valid;
    logic       bit_in;
    logic       start;
    logic       out_ready;
    logic       clr_err;
    logic [3:0] word_out;
    logic       word_valid;
    logic       frame_err;
    logic       overrun;

    int checks;
    int errors;

    serial_deserializer #(
        .WIDTH(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .start     (start),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .word_out  (word_out),
        .word_valid(word_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present inputs for one cycle; outputs afterwards reflect that edge.
    task automatic step(input logic v, input logic b, input logic s);
        bit_valid = v;
        bit_in    = b;
        start     = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; out_ready = 1'b0; clr_err = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        checks++;
        if ({word_out, word_valid, frame_err, overrun} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000000", {word_out, word_valid, frame_err, overrun});
        end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (word_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid got %b want 0", word_valid);
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 4'hB) begin
            errors++; $display("FAIL basic_word got v=%b w=%h want v=1 w=b", word_valid, word_out);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b0 || word_out !== 4'hB) begin
            errors++; $display("FAIL basic_retire got v=%b w=%h want v=0 w=b", word_valid, word_out);
        end
    endtask

    task automatic test_gaps;
        out_ready = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (word_valid !== 1'b0) begin
            errors++; $display("FAIL gaps_early_valid got %b want 0", word_valid);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 4'hC) begin
            errors++; $display("FAIL gaps_word got v=%b w=%h want v=1 w=c", word_valid, word_out);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun;
        out_ready = 1'b0;
        step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 4'hA || overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_first got v=%b w=%h o=%b want v=1 w=a o=0", word_valid, word_out, overrun);
        end
        step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 4'hA || overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_drop got v=%b w=%h o=%b want v=1 w=a o=1", word_valid, word_out, overrun);
        end
        clr_err = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        clr_err = 1'b0;
        checks++;
        if (overrun !== 1'b0 || word_valid !== 1'b1) begin
            errors++; $display("FAIL ovr_clear got o=%b v=%b want o=0 v=1", overrun, word_valid);
        end
        out_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b0 || word_out !== 4'hA) begin
            errors++; $display("FAIL ovr_drain got v=%b w=%h want v=0 w=a", word_valid, word_out);
        end
    endtask

    task automatic test_resync;
        out_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL resync_idle_err got %b want 0", frame_err);
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (frame_err !== 1'b1 || word_valid !== 1'b0) begin
            errors++; $display("FAIL resync_pulse got e=%b v=%b want e=1 v=0", frame_err, word_valid);
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (frame_err !== 1'b0 || word_valid !== 1'b0) begin
            errors++; $display("FAIL resync_pulse_end got e=%b v=%b want e=0 v=0", frame_err, word_valid);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 4'h6 || frame_err !== 1'b0) begin
            errors++; $display("FAIL resync_word got v=%b w=%h e=%b want v=1 w=6 e=0", word_valid, word_out, frame_err);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [3:0] frames [3];
        logic [3:0] f;
        frames[0] = 4'h9; frames[1] = 4'h3; frames[2] = 4'hF;
        for (int k = 0; k < 3; k++) begin
            f = frames[k];
            out_ready = 1'b0;
            for (int i = 3; i >= 0; i--) begin
                if (i == 0 && k > 0) out_ready = 1'b1;
                step(1'b1, f[i], (i == 3));
                if (i > 0 && k > 0) begin
                    checks++;
                    if (word_valid !== 1'b1 || word_out !== frames[k-1]) begin
                        errors++;
                        $display("FAIL b2b_hold[%0d] got v=%b w=%h want v=1 w=%h", k, word_valid, word_out, frames[k-1]);
                    end
                end
            end
            checks++;
            if (word_valid !== 1'b1 || word_out !== f || overrun !== 1'b0) begin
                errors++;
                $display("FAIL b2b_word[%0d] got v=%b w=%h o=%b want v=1 w=%h o=0", k, word_valid, word_out, overrun, f);
            end
        end
    endtask

    task automatic test_midframe_reset;
        out_ready = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if ({word_out, word_valid, frame_err, overrun} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs got %b want 0000000", {word_out, word_valid, frame_err, overrun});
        end
        out_ready = 1'b1;
        step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 4'h7 || frame_err !== 1'b0) begin
            errors++; $display("FAIL midreset_word got v=%b w=%h e=%b want v=1 w=7 e=0", word_valid, word_out, frame_err);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; start = 1'b0;
        out_ready = 1'b0; clr_err = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_resync();
        test_back_to_back();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
